// File: rtl/aplic_pkg.sv
// Shared types and constants for the APLIC MSI delivery path.
package aplic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        SEND,
        WAIT_RESP
    } msi_sched_state_e;

    localparam int          MsiDataW          = 32;
    localparam logic [63:0] ImsicBaseDefault  = 64'h2800_0000;
    localparam logic [63:0] HartStrideDefault = 64'h1000;

endpackage

// File: rtl/aplic_rr_picker.sv
// Round-robin search over the candidate vector, starting at rr_ptr and wrapping
// from NrSources-1 back to 1; source 0 is never returned.
module aplic_rr_picker #(
    parameter  int NrSources = 32,
    localparam int IdxW      = $clog2(NrSources)
) (
    input  logic [NrSources-1:0] cand,
    input  logic [IdxW-1:0]      rr_ptr,
    output logic                 found,
    output logic [IdxW-1:0]      idx
);

    always_comb begin
        int              s;
        logic [IdxW-1:0] sidx;
        found = 1'b0;
        idx   = '0;
        s     = 0;
        sidx  = '0;
        for (int k = 0; k < NrSources - 1; k++) begin
            s    = (int'(rr_ptr) - 1 + k) % (NrSources - 1) + 1;
            sidx = IdxW'(s);
            if (!found && cand[sidx] && (sidx != '0)) begin
                found = 1'b1;
                idx   = sidx;
            end
        end
    end

endmodule

// File: rtl/aplic_msi_scheduler.sv
// Picks a pending+enabled source round-robin, looks up its target, issues one
// MSI write and clears the pending bit once the write response returns.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for domain IE and a nonzero candidate set
// LOOKUP    | target registers sampled for the committed source
// SEND      | MSI request valid, address/data held until accepted
// WAIT_RESP | request accepted, waiting for the write response
module aplic_msi_scheduler
    import aplic_pkg::*;
#(
    parameter  int               NrSources  = 32,
    parameter  int               NrHarts    = 4,
    parameter  int               AddrW      = 64,
    parameter  logic [AddrW-1:0] ImsicBase  = AddrW'(ImsicBaseDefault),
    parameter  logic [AddrW-1:0] HartStride = AddrW'(HartStrideDefault),
    parameter  int               EiidW      = 11,
    localparam int               IdxW       = $clog2(NrSources)
) (
    input  logic                 i_clk,
    input  logic                 ni_rst,
    input  logic                 i_domain_ie,
    input  logic [NrSources-1:0] i_pending,
    input  logic [NrSources-1:0] i_enabled,
    output logic [IdxW-1:0]      o_lkp_idx,
    input  logic [13:0]          i_lkp_hart,
    input  logic [EiidW-1:0]     i_lkp_eiid,
    output logic [NrSources-1:0] o_clr_pending,
    output logic                 o_msi_valid,
    input  logic                 i_msi_ready,
    output logic [AddrW-1:0]     o_msi_addr,
    output logic [MsiDataW-1:0]  o_msi_data,
    input  logic                 i_bresp_valid,
    input  logic                 i_bresp_err,
    output logic                 o_busy,
    output logic                 o_err,
    input  logic                 i_err_clr
);

    msi_sched_state_e     state;
    logic [IdxW-1:0]      rr_ptr;
    logic [IdxW-1:0]      ptr_nxt;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_found;
    logic [NrSources-1:0] cand;
    logic                 eiid_zero;
    logic                 bad_hart;
    logic                 clr_fire;
    logic                 err_set;
    logic [AddrW-1:0]     msi_addr_nxt;

    assign cand = i_pending & i_enabled & {{(NrSources-1){1'b1}}, 1'b0};

    aplic_rr_picker #(.NrSources(NrSources)) u_picker (
        .cand   (cand),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign eiid_zero    = (i_lkp_eiid == '0);
    assign bad_hart     = (32'(i_lkp_hart) >= NrHarts);
    assign msi_addr_nxt = ImsicBase + AddrW'(i_lkp_hart) * HartStride;

    // Clear is gated by reset so an aborted transaction keeps its pending bit.
    assign clr_fire = ni_rst &&
                      (((state == LOOKUP) && (eiid_zero || bad_hart)) ||
                       ((state == WAIT_RESP) && i_bresp_valid));
    assign err_set  = ((state == LOOKUP) && !eiid_zero && bad_hart) ||
                      ((state == WAIT_RESP) && i_bresp_valid && i_bresp_err);

    assign o_clr_pending = clr_fire ? (NrSources'(1) << o_lkp_idx) : '0;
    assign ptr_nxt       = (o_lkp_idx == IdxW'(NrSources - 1)) ? IdxW'(1)
                                                                : o_lkp_idx + IdxW'(1);
    assign o_busy        = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!ni_rst) begin
            state       <= IDLE;
            rr_ptr      <= IdxW'(1);
            o_lkp_idx   <= '0;
            o_msi_valid <= 1'b0;
            o_msi_addr  <= '0;
            o_msi_data  <= '0;
            o_err       <= 1'b0;
        end else begin
            if (err_set) begin
                o_err <= 1'b1;
            end else if (i_err_clr) begin
                o_err <= 1'b0;
            end
            if (clr_fire) begin
                rr_ptr <= ptr_nxt;
            end
            case (state)
                IDLE: begin
                    if (i_domain_ie && pick_found) begin
                        o_lkp_idx <= pick_idx;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (eiid_zero || bad_hart) begin
                        state <= IDLE;
                    end else begin
                        o_msi_addr  <= msi_addr_nxt;
                        o_msi_data  <= MsiDataW'(i_lkp_eiid);
                        o_msi_valid <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (i_msi_ready) begin
                        o_msi_valid <= 1'b0;
                        state       <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (i_bresp_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aplic_msi_scheduler.sv
// Bench for aplic_msi_scheduler: directed scenarios then randomized transactions
// checked against a transaction-level round-robin/delivery model.
module tb_aplic_msi_scheduler;

    logic        i_clk;
    logic        ni_rst;
    logic        i_domain_ie;
    logic [31:0] pending;
    logic [31:0] enabled;
    logic [4:0]  o_lkp_idx;
    logic [13:0] i_lkp_hart;
    logic [10:0] i_lkp_eiid;
    logic [31:0] o_clr_pending;
    logic        o_msi_valid;
    logic        i_msi_ready;
    logic [63:0] o_msi_addr;
    logic [31:0] o_msi_data;
    logic        i_bresp_valid;
    logic        i_bresp_err;
    logic        o_busy;
    logic        o_err;
    logic        i_err_clr;

    logic [13:0] tgt_hart [32];
    logic [10:0] tgt_eiid [32];

    int checks   = 0;
    int failures = 0;
    int model_ptr;
    bit model_err;

    assign i_lkp_hart = tgt_hart[o_lkp_idx];
    assign i_lkp_eiid = tgt_eiid[o_lkp_idx];

    aplic_msi_scheduler dut (
        .i_clk         (i_clk),
        .ni_rst        (ni_rst),
        .i_domain_ie   (i_domain_ie),
        .i_pending     (pending),
        .i_enabled     (enabled),
        .o_lkp_idx     (o_lkp_idx),
        .i_lkp_hart    (i_lkp_hart),
        .i_lkp_eiid    (i_lkp_eiid),
        .o_clr_pending (o_clr_pending),
        .o_msi_valid   (o_msi_valid),
        .i_msi_ready   (i_msi_ready),
        .o_msi_addr    (o_msi_addr),
        .o_msi_data    (o_msi_data),
        .i_bresp_valid (i_bresp_valid),
        .i_bresp_err   (i_bresp_err),
        .o_busy        (o_busy),
        .o_err         (o_err),
        .i_err_clr     (i_err_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Next source in ascending order from ptr, skipping 0, wrapping 31 -> 1.
    function automatic int rr_pick(input logic [31:0] c, input int ptr);
        int s = ptr;
        for (int k = 0; k < 31; k++) begin
            if (c[s[4:0]]) return s;
            s = (s == 31) ? 1 : s + 1;
        end
        return 0;
    endfunction

    function automatic int ptr_after(input int idx);
        return (idx == 31) ? 1 : idx + 1;
    endfunction

    task automatic do_reset();
        ni_rst = 1'b0;
        @(negedge i_clk);
        i_bresp_valid = 1'b0;
        i_bresp_err   = 1'b0;
        i_msi_ready   = 1'b0;
        i_err_clr     = 1'b0;
        chk_val("rst_busy",  o_busy, 0);
        chk_val("rst_valid", o_msi_valid, 0);
        chk_val("rst_err",   o_err, 0);
        chk_val("rst_addr",  o_msi_addr, 0);
        chk_val("rst_data",  o_msi_data, 0);
        chk_val("rst_idx",   o_lkp_idx, 0);
        chk_val("rst_clr",   o_clr_pending, 0);
        ni_rst    = 1'b1;
        model_ptr = 1;
        model_err = 1'b0;
    endtask

    // Starts and ends at a falling edge where the DUT sits in IDLE.
    task automatic run_txn(input int rdy_dly, input int rsp_dly, input bit rsp_err,
                           input bit drop_ie, input bit rst_wait, input bit err_clr,
                           input bit yank);
        logic [31:0] cand;
        logic [31:0] bit_v;
        logic [63:0] exp_addr;
        logic [31:0] exp_data;
        int          idx;
        cand      = pending & enabled;
        cand[0]   = 1'b0;
        i_err_clr = err_clr;
        if (err_clr) model_err = 1'b0;
        if (!i_domain_ie || cand == 0) begin
            @(negedge i_clk);
            i_err_clr = 1'b0;
            chk_val("hold_busy", o_busy, 0);
            chk_val("hold_clr",  o_clr_pending, 0);
            chk_val("hold_err",  o_err, model_err);
            return;
        end
        idx   = rr_pick(cand, model_ptr);
        bit_v = 32'd1 << idx;
        @(negedge i_clk);
        chk_val("lkp_idx",   o_lkp_idx, idx);
        chk_val("lkp_valid", o_msi_valid, 0);
        chk_val("lkp_busy",  o_busy, 1);
        if (tgt_eiid[idx] == 0 || tgt_hart[idx] >= 4) begin
            chk_val("lkp_clr", o_clr_pending, bit_v);
            if (tgt_eiid[idx] != 0) model_err = 1'b1;
            pending[idx[4:0]] = 1'b0;
            model_ptr = ptr_after(idx);
            @(negedge i_clk);
            i_err_clr = 1'b0;
            chk_val("drop_busy",  o_busy, 0);
            chk_val("drop_valid", o_msi_valid, 0);
            chk_val("drop_err",   o_err, model_err);
            return;
        end
        chk_val("lkp_noclr", o_clr_pending, 0);
        i_err_clr = 1'b0;
        if (yank) enabled[idx[4:0]] = 1'b0;
        exp_addr    = 64'h2800_0000 + 64'(tgt_hart[idx]) * 64'h1000;
        exp_data    = 32'(tgt_eiid[idx]);
        i_msi_ready = (rdy_dly == 0);
        @(negedge i_clk);
        chk_val("send_valid", o_msi_valid, 1);
        chk_val("send_addr",  o_msi_addr, exp_addr);
        chk_val("send_data",  o_msi_data, exp_data);
        chk_val("send_err",   o_err, model_err);
        if (drop_ie) i_domain_ie = 1'b0;
        for (int n = 0; n < rdy_dly; n++) begin
            @(negedge i_clk);
            chk_val("stall_valid", o_msi_valid, 1);
            chk_val("stall_addr",  o_msi_addr, exp_addr);
            chk_val("stall_data",  o_msi_data, exp_data);
            if (n == rdy_dly - 1) i_msi_ready = 1'b1;
        end
        @(negedge i_clk);
        i_msi_ready = 1'b0;
        chk_val("wait_valid", o_msi_valid, 0);
        chk_val("wait_busy",  o_busy, 1);
        if (rst_wait) begin
            i_bresp_valid = 1'b1;
            ni_rst        = 1'b0;
            #1;
            chk_val("rst_noclr", o_clr_pending, 0);
            do_reset();
            return;
        end
        for (int n = 0; n < rsp_dly; n++) begin
            chk_val("wait_noclr", o_clr_pending, 0);
            @(negedge i_clk);
        end
        i_bresp_valid = 1'b1;
        i_bresp_err   = rsp_err;
        #1;
        chk_val("resp_clr", o_clr_pending, bit_v);
        pending[idx[4:0]] = 1'b0;
        model_ptr = ptr_after(idx);
        if (rsp_err) model_err = 1'b1;
        @(negedge i_clk);
        i_bresp_valid = 1'b0;
        i_bresp_err   = 1'b0;
        chk_val("done_busy",  o_busy, 0);
        chk_val("done_valid", o_msi_valid, 0);
        chk_val("done_err",   o_err, model_err);
    endtask

    initial begin
        ni_rst        = 1'b0;
        i_domain_ie   = 1'b1;
        pending       = '0;
        enabled       = '1;
        i_msi_ready   = 1'b0;
        i_bresp_valid = 1'b0;
        i_bresp_err   = 1'b0;
        i_err_clr     = 1'b0;
        model_ptr     = 1;
        model_err     = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tgt_hart[i] = 14'd0;
            tgt_eiid[i] = 11'd1;
        end
        @(negedge i_clk);
        pending = 32'h0000_0020;
        do_reset();

        // single source 5 -> hart 2, EIID 9
        pending     = 32'd1 << 5;
        tgt_hart[5] = 14'd2;
        tgt_eiid[5] = 11'd9;
        run_txn(0, 0, 0, 0, 0, 0, 0);

        // round-robin order from pointer 1
        do_reset();
        pending = (32'd1 << 3) | (32'd1 << 7) | (32'd1 << 12);
        for (int i = 0; i < 3; i++) run_txn(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        pending = 32'd1 << 7;
        run_txn(0, 1, 0, 0, 0, 0, 0);
        pending = (32'd1 << 3) | (32'd1 << 12);
        run_txn(1, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0);

        // EIID 0 drop, then out-of-range hart
        tgt_eiid[4] = 11'd0;
        pending     = 32'd1 << 4;
        run_txn(0, 0, 0, 0, 0, 0, 0);
        tgt_hart[6] = 14'd9;
        tgt_eiid[6] = 11'd5;
        pending     = 32'd1 << 6;
        run_txn(0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 1, 0);

        // backpressure and error response, then clear
        tgt_hart[10] = 14'd3;
        tgt_eiid[10] = 11'h7FF;
        pending      = 32'd1 << 10;
        run_txn(5, 2, 1, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 1, 0);

        // domain IE gating
        i_domain_ie = 1'b0;
        pending     = 32'h0000_0006;
        run_txn(0, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0);
        i_domain_ie = 1'b1;
        run_txn(2, 1, 0, 1, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0);
        i_domain_ie = 1'b1;

        // reset in WAIT_RESP, then re-delivery
        pending     = 32'd1 << 9;
        tgt_hart[9] = 14'd1;
        tgt_eiid[9] = 11'd20;
        run_txn(0, 0, 0, 0, 1, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0);

        // randomized traffic
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) != 0)
                pending = pending | (32'd1 << $urandom_range(1, 31));
            if ($urandom_range(0, 4) == 0)
                pending = pending | ($urandom & $urandom);
            enabled     = ~($urandom & $urandom & $urandom);
            i_domain_ie = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 32; i++) begin
                tgt_hart[i] = ($urandom_range(0, 15) == 0) ? 14'h3FFF
                                                          : 14'($urandom_range(0, 5));
                tgt_eiid[i] = ($urandom_range(0, 5) == 0) ? 11'd0
                                                         : 11'($urandom_range(1, 2047));
            end
            run_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
